// File: rtl/conv_mac_engine.sv
// conv_mac_engine: serial KxK dot product of unsigned pixels and signed
// coefficients, one tap per clock, followed by shift, ReLU and saturation. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module conv_mac_engine #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int K      = 3,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16,
    parameter int SH_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [K*K*DATA_W-1:0]   image,
    input  logic [K*K*COEF_W-1:0]   kernel,
    input  logic [SH_W-1:0]         shift,
    input  logic                    relu_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        result,
    output logic                    sat
);

    localparam int c_taps  = K * K;
    localparam int c_idx_w = (c_taps > 1) ? $clog2(c_taps) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_taps - 1);
    localparam logic signed [ACC_W-1:0] c_out_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_out_min = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_consume;

    logic [c_idx_w-1:0]         r_tap_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic [K*K*DATA_W-1:0]      r_image;
    logic [K*K*COEF_W-1:0]      r_kernel;
    logic [SH_W-1:0]            r_shift;
    logic                       r_relu;
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic [OUT_W-1:0]           r_result;
    logic                       r_sat;

    logic signed [DATA_W:0]         w_pix;
    logic signed [COEF_W-1:0]       w_coef;
    logic signed [DATA_W+COEF_W:0]  w_prod;
    logic signed [ACC_W-1:0]        w_prod_ext;
    logic signed [ACC_W-1:0]        w_final;
    logic signed [ACC_W-1:0]        w_shifted;
    logic signed [ACC_W-1:0]        w_relu;
    logic [OUT_W-1:0]               w_clamped;
    logic                           w_clamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_last    = 1'b0;
        w_consume = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_MAC;
                end
            end
            S_MAC: begin
                if (r_tap_idx == c_last) begin
                    w_last = 1'b1;
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_consume = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pixel is zero-extended by one bit so the signed multiply treats it as unsigned.
    assign w_pix      = $signed({1'b0, r_image[r_tap_idx*DATA_W +: DATA_W]});
    assign w_coef     = $signed(r_kernel[r_tap_idx*COEF_W +: COEF_W]);
    assign w_prod     = w_pix * w_coef;
    assign w_prod_ext = {{(ACC_W-DATA_W-COEF_W-1){w_prod[DATA_W+COEF_W]}}, w_prod};
    assign w_final    = r_acc + w_prod_ext;
    assign w_shifted  = w_final >>> r_shift;
    assign w_relu     = (r_relu && w_shifted[ACC_W-1]) ? '0 : w_shifted;

    always_comb begin
        w_clamped = w_relu[OUT_W-1:0];
        w_clamp   = 1'b0;
        if (w_relu > c_out_max) begin
            w_clamped = c_out_max[OUT_W-1:0];
            w_clamp   = 1'b1;
        end else if (w_relu < c_out_min) begin
            w_clamped = c_out_min[OUT_W-1:0];
            w_clamp   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tap_idx   <= '0;
            r_acc       <= '0;
            r_image     <= '0;
            r_kernel    <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_sat       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_image    <= image;
                r_kernel   <= kernel;
                r_shift    <= shift;
                r_relu     <= relu_en;
                r_acc      <= '0;
                r_tap_idx  <= '0;
                r_in_ready <= 1'b0;
            end else if (r_state == S_IDLE) begin
                r_in_ready <= 1'b1;
            end

            if (r_state == S_MAC) begin
                r_acc     <= w_final;
                r_tap_idx <= r_tap_idx + 1'b1;
            end

            if (w_last) begin
                r_result    <= w_clamped;
                r_sat       <= w_clamp;
                r_out_valid <= 1'b1;
            end

            if (w_consume) begin
                r_out_valid <= 1'b0;
                r_in_ready  <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign sat       = r_sat;

endmodule

`default_nettype wire

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
- Parametrised successor to the fixed 3x3 convolution unit: one KxK window dot product per transaction, using a serial multiply-accumulate of one tap per clock.
- Inputs are unsigned pixels and signed coefficients.
- Adds valid/ready handshakes on input and output, a runtime right-shift, optional ReLU and signed saturation with an overflow flag.
- Sits between the window line-buffer and the feature-map writeback stage of the accelerator datapath.

Parameters:
- DATA_W, 8, pixel width, unsigned.
- COEF_W, 8, coefficient width, signed two's complement.
- K, 3, kernel side; window holds K*K taps.
- ACC_W, 24, accumulator width, signed; must satisfy ACC_W >= DATA_W+COEF_W+1+clog2(K*K).
- OUT_W, 16, result width, signed.
- SH_W, 5, width of the shift input.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  engine can accept operands.
- image  in  K*K*DATA_W  tap i at bits [i*DATA_W +: DATA_W]; tap 0 in the LSBs.
- kernel  in  K*K*COEF_W  tap i at bits [i*COEF_W +: COEF_W].
- shift  in  SH_W  arithmetic right-shift applied to the final sum.
- relu_en  in  1  clamp negative results to 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  OUT_W  signed convolution output.
- sat  out  1  result was saturated; qualified by out_valid.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, tap_idx=0, accumulator=0.
  - in_ready=0, out_valid=0, result=0, sat=0.
  - in_ready is registered and rises on the first clock edge after rst deasserts.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: latch image, kernel, shift and relu_en into internal registers; clear accumulator; tap_idx=0; in_ready<=0; go to MAC.
  - Input ports are ignored after acceptance.
- MAC:
  - Each edge adds prod(tap_idx) to the accumulator, then increments tap_idx.
  - prod is the zero-extended pixel (DATA_W+1 bits, signed) times the coefficient, sign-extended to ACC_W.
  - On the edge processing tap K*K-1:
    - final = acc + prod.
    - s = final >>> shift (arithmetic shift, floor rounding).
    - If relu_en && s<0, then s=0.
    - Saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat=1 iff clamping occurred.
    - Register result and sat; out_valid<=1; go to OUT.
  - Latency: out_valid is high exactly K*K edges after the acceptance edge (9 for K=3).
- OUT:
  - result and sat are held stable while out_valid && !out_ready, for any number of cycles.
  - On an edge with out_ready=1: out_valid<=0, in_ready<=1, go to IDLE.
  - There is no bypass. A new input cannot be accepted on the same edge the result is consumed. Minimum period per transaction is K*K+2 cycles.
- Between transactions, result and sat keep their last values. They are meaningful only while out_valid=1.
- out_ready asserted while out_valid=0 has no effect. in_valid while in_ready=0 is ignored; the upstream holds its data.
- shift >= ACC_W yields 0 for non-negative sums and -1 for negative sums (pure arithmetic shift semantics).
- Reset asserted mid-MAC or mid-OUT aborts the transaction. No partial result is ever presented after reset.
- The accumulator does not wrap for legal parameters. This is guaranteed by the ACC_W rule, and the bench checks that rule at elaboration.

Test Plan:
- Golden window. Stimulus: image=72'h5A5582_9B3A84_A2CF73, kernel=72'h0100FF_0100FF_0100FF, shift=0, relu_en=0, out_ready=1. Response: result=30, sat=0, out_valid high 9 cycles after acceptance, in_ready back high 2 cycles later.
- Saturation. Stimulus: all pixels 0xFF with all coefficients 0x7F, then all coefficients 0x80. Response: 291465 clamps to 32767 with sat=1; -293760 clamps to -32768 with sat=1.
- ReLU and shift.
  - Golden image with kernel negated (0xFF/0x00/0x01 pattern swapped). Response: relu_en=0 gives -30 (16'hFFE2); relu_en=1 gives 0 with sat=0.
  - All pixels 0xFF, all coefficients 0x01, shift=3. Response: result=286 (2295>>>3).
- Backpressure. Stimulus: hold out_ready=0 for 6 cycles after out_valid, toggle image/kernel and pulse in_valid meanwhile. Response: result stable at its first value, in_ready=0 throughout, only one transaction completes.
- Reset mid-operation. Stimulus: assert rst asynchronously during tap 4, release, then rerun the golden window. Response: outputs zero immediately, in_ready=0 until the first edge after release, second run yields 30.
- Back-to-back. Stimulus: in_valid held high with 3 distinct windows and out_ready=1. Response: results arrive in order at 11-cycle spacing, none dropped or duplicated.
